// File: rtl/mul_booth_csa_seq.sv
// Sequential radix-4 Booth signed multiplier that folds two partial products per cycle
// into a carry-save accumulator through a single 2N-bit 4:2 reducer.

module Reducer4to2_Nbit #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] s1;
    logic [W-1:0] maj1;
    logic [W-1:0] c1;
    logic [W-1:0] maj2;

    // Two carry-save layers; carry_o is already aligned so sum_o + carry_o equals the input sum mod 2^W.
    assign s1      = a_i ^ b_i ^ c_i;
    assign maj1    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign c1      = {maj1[W-2:0], cin_i};
    assign sum_o   = s1 ^ c1 ^ d_i;
    assign maj2    = (s1 & c1) | (s1 & d_i) | (c1 & d_i);
    assign carry_o = {maj2[W-2:0], 1'b0};

endmodule

module mul_booth_csa_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         iStart,
    input  logic [N-1:0] iA,
    input  logic [N-1:0] iB,
    output logic         oBusy,
    output logic         oDone,
    output logic [N-1:0] oHi,
    output logic [N-1:0] oLo
);

    localparam int W      = 2 * N;
    localparam int DIGITS = N / 4;
    localparam int CW     = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
    localparam logic [W-1:0]  ONE  = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FIXUP,
        RESOLVE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  multA_q, multA_d;
    logic [N-1:0]  multB_q, multB_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [W-1:0]  carry_q, carry_d;
    logic [W-1:0]  corr_q, corr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;

    logic [N:0]    bExt;
    int unsigned   shLo;
    int unsigned   shHi;
    logic [2:0]    grpLo;
    logic [2:0]    grpHi;
    logic [W-1:0]  ppLo;
    logic [W-1:0]  ppHi;
    logic [W-1:0]  corrLo;
    logic [W-1:0]  corrHi;
    logic [W-1:0]  redC;
    logic [W-1:0]  redD;
    logic [W-1:0]  redSum;
    logic [W-1:0]  redCarry;
    logic [W-1:0]  product;

    // The magnitude is inverted before shifting, so the vacated low bits stay zero
    // and the two's-complement correction for digit k is exactly 4^k.
    function automatic logic [W-1:0] boothPp(input logic [W-1:0] a,
                                             input logic [2:0]   grp,
                                             input int unsigned  sh);
        logic [W-1:0] mag;
        case (grp)
            3'b001, 3'b010: mag = a;
            3'b011:         mag = a << 1;
            3'b100:         mag = ~(a << 1);
            3'b101, 3'b110: mag = ~a;
            default:        mag = '0;
        endcase
        return mag << sh;
    endfunction

    function automatic logic boothNeg(input logic [2:0] grp);
        return grp[2] & ~(grp[1] & grp[0]);
    endfunction

    assign bExt   = {multB_q, 1'b0};
    assign shLo   = 32'(cnt_q) << 2;
    assign shHi   = shLo + 32'd2;
    assign grpLo  = bExt[shLo +: 3];
    assign grpHi  = bExt[shHi +: 3];
    assign ppLo   = boothPp(multA_q, grpLo, shLo);
    assign ppHi   = boothPp(multA_q, grpHi, shHi);
    assign corrLo = boothNeg(grpLo) ? (ONE << shLo) : '0;
    assign corrHi = boothNeg(grpHi) ? (ONE << shHi) : '0;
    assign product = sum_q + carry_q;

    Reducer4to2_Nbit #(.W(W)) uReducer (
        .a_i     (sum_q),
        .b_i     (carry_q),
        .c_i     (redC),
        .d_i     (redD),
        .cin_i   (1'b0),
        .sum_o   (redSum),
        .carry_o (redCarry)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            multA_q <= '0;
            multB_q <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            corr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            multA_q <= multA_d;
            multB_q <= multB_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            corr_q  <= corr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        multA_d = multA_q;
        multB_d = multB_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        corr_d  = corr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        redC    = '0;
        redD    = '0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    multA_d = {{N{iA[N-1]}}, iA};
                    multB_d = iB;
                    sum_d   = '0;
                    carry_d = '0;
                    corr_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                redC    = ppLo;
                redD    = ppHi;
                sum_d   = redSum;
                carry_d = redCarry;
                corr_d  = corr_q | corrLo | corrHi;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                redC    = corr_q;
                sum_d   = redSum;
                carry_d = redCarry;
                state_d = RESOLVE;
            end
            RESOLVE: begin
                hi_d    = product[W-1:N];
                lo_d    = product[N-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oHi   = hi_q;
    assign oLo   = lo_q;

endmodule

// File: tb/tb_mul_booth_csa_seq.sv
// Bench for mul_booth_csa_seq: vector table, hand-written corner sequences and random pairs,
// with a scoreboard queue checked whenever oDone pulses.

module tb_mul_booth_csa_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic         iStart = 1'b0;
    logic [N-1:0] iA = '0;
    logic [N-1:0] iB = '0;
    logic         oBusy;
    logic         oDone;
    logic [N-1:0] oHi;
    logic [N-1:0] oLo;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    logic [63:0] sbExp[$];
    int          sbStart[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[9];

    mul_booth_csa_seq #(.N(N)) dut (
        .clk    (clk),
        .nRst   (nRst),
        .iStart (iStart),
        .iA     (iA),
        .iB     (iB),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oHi    (oHi),
        .oLo    (oLo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called one time unit after an edge; returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        iA = a;
        iB = b;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        sbExp.push_back(exp);
        sbStart.push_back(cycle);
    endtask

    task automatic waitDone(output int busyCnt);
        bit seen;
        seen = 1'b0;
        busyCnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (oDone === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (oBusy === 1'b1) busyCnt++;
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL doneTimeout: no oDone within 40 cycles, expected one");
        end
    endtask

    // Scoreboard side: every oDone pops one expected product and its start cycle.
    initial begin
        logic [63:0] e;
        int          st;
        forever begin
            @(posedge clk);
            #1;
            if (oDone === 1'b1) begin
                if (sbExp.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedDone: oDone=1 with product %h, expected no done", {oHi, oLo});
                end else begin
                    e  = sbExp.pop_front();
                    st = sbStart.pop_front();
                    checkOutput("product", {oHi, oLo}, e);
                    checkOutput("latency", 64'(cycle - st), 64'd10);
                    checkOutput("busyAtDone", {63'b0, oBusy}, 64'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          busyCnt;
        int          doneCnt;
        bit          pushed2;
        logic [31:0] ra;
        logic [31:0] rb;
        longint      sa;
        longint      sb;

        vecs[0] = '{32'h00000003, 32'h00000005, 64'h00000000_0000000F};
        vecs[1] = '{32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        vecs[3] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
        vecs[5] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
        vecs[6] = '{32'h00000000, 32'hDEADBEEF, 64'h00000000_00000000};
        vecs[7] = '{32'h12345678, 32'h00000010, 64'h00000001_23456780};
        vecs[8] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF_80000001};

        #3;
        checkOutput("resetHiLo", {oHi, oLo}, 64'd0);
        checkOutput("resetFlags", {62'b0, oBusy, oDone}, 64'd0);
        #20 nRst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic 3*5 with busy window");
        applyStimulus(32'd3, 32'd5, 64'h0000000F);
        waitDone(busyCnt);
        checkOutput("busyCycles", 64'(busyCnt), 64'd10);

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p);
            waitDone(busyCnt);
        end

        $display("[TB] start while busy / back-to-back");
        iA = 32'd2;
        iB = 32'd2;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        sbExp.push_back(64'd4);
        sbStart.push_back(cycle);
        iA = 32'd9;
        iB = 32'd9;
        pushed2 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (oDone === 1'b1 && !pushed2) begin
                sbExp.push_back(64'd81);
                sbStart.push_back(cycle + 1);
                pushed2 = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        iStart = 1'b0;
        checkOutput("secondStartSeen", {63'b0, pushed2}, 64'd1);
        waitDone(busyCnt);

        $display("[TB] asynchronous reset mid-operation");
        iA = 32'h12345678;
        iB = 32'h12345678;
        iStart = 1'b1;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        nRst = 1'b0;
        #1;
        checkOutput("midResetHiLo", {oHi, oLo}, 64'd0);
        checkOutput("midResetFlags", {62'b0, oBusy, oDone}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #4;
        nRst = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (oDone === 1'b1) doneCnt++;
        end
        checkOutput("noDoneAfterReset", 64'(doneCnt), 64'd0);
        applyStimulus(32'd6, 32'd7, 64'd42);
        waitDone(busyCnt);

        $display("[TB] random signed pairs");
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = 32'h80000000;
                2: ra = 32'hFFFFFFFF;
                3: rb = 32'h7FFFFFFF;
                default: ;
            endcase
            sa = $signed(ra);
            sb = $signed(rb);
            applyStimulus(ra, rb, 64'(sa * sb));
            waitDone(busyCnt);
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 64'(sbExp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
